// File: rtl/rsa_host_if_if.sv
// Stream and RSA-core bus bundle for rsa_host_if.
// slave: the host-interface block; master: the surrounding environment
// (operand source, result sink and RSA core).
interface rsa_host_if_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       rsa_we;
    logic       rsa_oe;
    logic       rsa_start;
    logic [1:0] rsa_reg_sel;
    logic [4:0] rsa_addr;
    logic [7:0] rsa_wdata;
    logic [7:0] rsa_rdata;
    logic       rsa_ready;

    modport slave (
        input  in_valid, in_data, out_ready, rsa_rdata, rsa_ready,
        output in_ready, out_valid, out_data,
        output rsa_we, rsa_oe, rsa_start, rsa_reg_sel, rsa_addr, rsa_wdata
    );

    modport master (
        output in_valid, in_data, out_ready, rsa_rdata, rsa_ready,
        input  in_ready, out_valid, out_data,
        input  rsa_we, rsa_oe, rsa_start, rsa_reg_sel, rsa_addr, rsa_wdata
    );
endinterface

// File: rtl/rsa_host_if.sv
// Host-side byte interface to a 256-bit RSA core: streams 96 operand bytes
// (base, exponent, modulus) into the core, pulses start, waits for the
// result and streams its 32 bytes back out. All outputs come from flops.
module rsa_host_if (
    input  logic         clk,
    input  logic         reset,
    rsa_host_if_if.slave bus,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_RD,
        S_RD_LAT,
        S_SEND
    } state_t;

    state_t     state, state_nx;
    logic [6:0] n, n_nx;
    logic [4:0] k, k_nx;
    logic       load_hs, send_hs;

    logic       we_nx, oe_nx, start_nx;
    logic       in_ready_nx, out_valid_nx, busy_nx, done_nx;
    logic [1:0] sel_nx;
    logic [4:0] addr_nx;
    logic [7:0] wdata_nx, out_data_nx;

    // in_ready is registered as (state == S_LOAD), so the state alone qualifies it
    assign load_hs = (state == S_LOAD) && bus.in_valid;
    assign send_hs = (state == S_SEND) && bus.out_ready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   state_nx = S_LOAD;
            S_LOAD:   if (load_hs && (n == 7'd95)) state_nx = S_START;
            S_START:  state_nx = S_WAIT;
            // rsa_ready is not trusted while the start pulse is still on the bus
            S_WAIT:   if (bus.rsa_ready && !bus.rsa_start) state_nx = S_RD;
            S_RD:     state_nx = S_RD_LAT;
            S_RD_LAT: state_nx = S_SEND;
            S_SEND:   if (send_hs) state_nx = (k == 5'd31) ? S_LOAD : S_RD;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Output/datapath next values; registered below so every output is a flop
    always_comb begin
        n_nx         = n;
        k_nx         = k;
        we_nx        = 1'b1;
        oe_nx        = 1'b1;
        start_nx     = (state == S_START);
        in_ready_nx  = (state_nx == S_LOAD);
        out_valid_nx = (state_nx == S_SEND);
        busy_nx      = !((state_nx == S_IDLE) || (state_nx == S_LOAD));
        done_nx      = send_hs && (k == 5'd31);
        sel_nx       = bus.rsa_reg_sel;
        addr_nx      = bus.rsa_addr;
        wdata_nx     = bus.rsa_wdata;
        out_data_nx  = bus.out_data;

        if (load_hs) begin
            we_nx    = 1'b0;
            wdata_nx = bus.in_data;
            addr_nx  = n[4:0];
            sel_nx   = n[6:5] + 2'd1;
            n_nx     = (n == 7'd95) ? 7'd0 : n + 7'd1;
        end

        if ((state == S_WAIT) && (state_nx == S_RD)) begin
            k_nx = 5'd0;
        end else if (send_hs && (k != 5'd31)) begin
            k_nx = k + 5'd1;
        end

        if (state_nx == S_RD) begin
            oe_nx   = 1'b0;
            sel_nx  = 2'd0;
            addr_nx = k_nx;
        end

        if (state == S_RD_LAT) begin
            out_data_nx = bus.rsa_rdata;
        end
    end

    // Output and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n               <= '0;
            k               <= '0;
            bus.rsa_we      <= 1'b1;
            bus.rsa_oe      <= 1'b1;
            bus.rsa_start   <= 1'b0;
            bus.rsa_reg_sel <= '0;
            bus.rsa_addr    <= '0;
            bus.rsa_wdata   <= '0;
            bus.in_ready    <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.out_data    <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            n               <= n_nx;
            k               <= k_nx;
            bus.rsa_we      <= we_nx;
            bus.rsa_oe      <= oe_nx;
            bus.rsa_start   <= start_nx;
            bus.rsa_reg_sel <= sel_nx;
            bus.rsa_addr    <= addr_nx;
            bus.rsa_wdata   <= wdata_nx;
            bus.in_ready    <= in_ready_nx;
            bus.out_valid   <= out_valid_nx;
            bus.out_data    <= out_data_nx;
            busy            <= busy_nx;
            done            <= done_nx;
        end
    end

endmodule

// File: doc/rsa_host_if.md
RSA_HOST_IF -- requirements
Module: rsa_host_if

Interface
REQ-001 The block SHALL have one clock, clk; reset is asynchronous and active-high, named reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; forces all state to reset values.
REQ-004 in_valid  input  1  operand byte available on in_data.
REQ-005 in_data  input  8  operand byte stream.
REQ-006 in_ready  output  1  block accepts in_data this cycle.
REQ-007 out_valid  output  1  result byte valid on out_data.
REQ-008 out_data  output  8  result byte stream.
REQ-009 out_ready  input  1  downstream accepts out_data.
REQ-010 rsa_we  output  1  active-low write strobe to the RSA core.
REQ-011 rsa_oe  output  1  active-low read strobe to the RSA core.
REQ-012 rsa_start  output  1  one-cycle compute-start pulse.
REQ-013 rsa_reg_sel  output  2  core register select: 0 result, 1 base, 2 exponent, 3 modulus.
REQ-014 rsa_addr  output  5  byte index within the 256-bit register, 0 = LSB.
REQ-015 rsa_wdata  output  8  write byte to the core.
REQ-016 rsa_rdata  input  8  core read byte, registered in the core, valid the cycle after the rsa_oe strobe cycle.
REQ-017 rsa_ready  input  1  core result complete.
REQ-018 busy  output  1  high in every state except IDLE and LOAD.
REQ-019 done  output  1  one-cycle pulse after the last result byte is accepted.

Function
REQ-020 FSM states: IDLE, LOAD, START, WAIT, RD, RD_LAT, SEND.
REQ-021 IDLE SHALL last exactly one cycle, then go to LOAD.
REQ-022 In LOAD, in_ready SHALL be 1; in all other states, in_ready SHALL be 0.
REQ-023 Each LOAD handshake (in_valid & in_ready) SHALL increment a 7-bit byte counter n (0..95).
REQ-024 Each handshake SHALL register rsa_we=0, rsa_wdata=in_data, rsa_addr=n[4:0], and rsa_reg_sel = 1/2/3 for n[6:5] = 0/1/2 (base, exponent, modulus).
REQ-025 Each write strobe SHALL last exactly the cycle after the handshake; with no handshake, rsa_we SHALL return to 1.
REQ-026 LOAD SHALL sustain back-to-back writes at 1 byte/cycle; gaps SHALL produce no duplicate strobes.
REQ-027 After the handshake with n=95, the FSM SHALL go to START and clear n.
REQ-028 rsa_start SHALL be 1 for exactly the cycle after the last write strobe, then the FSM SHALL go to WAIT.
REQ-029 rsa_ready SHALL be ignored during the START cycle.
REQ-030 WAIT SHALL hold until rsa_ready=1 is sampled, then go to RD with result index k=0.
REQ-031 RD SHALL drive rsa_oe=0, rsa_reg_sel=0 and rsa_addr=k for one cycle.
REQ-032 RD_LAT SHALL last one cycle; at its end, out_data SHALL capture rsa_rdata.
REQ-033 SEND SHALL hold out_valid=1 with out_data stable until out_ready=1.
REQ-034 On a SEND handshake: if k<31, the FSM SHALL go to RD with k+1; if k=31, done SHALL pulse and the FSM SHALL go to LOAD.
REQ-035 rsa_we and rsa_oe SHALL never be 0 in the same cycle.
REQ-036 rsa_reg_sel/rsa_addr/rsa_wdata SHALL be stable through every strobe cycle.
REQ-037 Every bus output SHALL be driven directly from a flop.

Reset
REQ-038 While reset=1, outputs SHALL be: rsa_we=1, rsa_oe=1, rsa_start=0, rsa_reg_sel=0, rsa_addr=0, rsa_wdata=0, in_ready=0, out_valid=0, out_data=0, busy=0, done=0.
REQ-039 While reset=1, the FSM SHALL be in IDLE with n=0 and k=0.
REQ-040 Reset asserted mid-operation (any state) SHALL abort the transfer with no further strobes; after release, loading SHALL restart at n=0.

Verification
REQ-041 Reset during LOAD at n=40 -> strobes immediately inactive; after release, 1 IDLE cycle, then the first byte 0x11 writes reg_sel=1, addr=0, wdata=0x11.
REQ-042 96 back-to-back bytes with value=index -> 96 consecutive we strobes; byte 0 -> sel1/addr0/0x00; byte 33 -> sel2/addr1/0x21; byte 95 -> sel3/addr31/0x5F; rsa_start high for one cycle immediately after.
REQ-043 in_valid toggled 1,0,0,1 -> exactly two write strobes, rsa_we=1 in gap cycles, addresses consecutive.
REQ-044 rsa_ready held 1 through START, low 100 cycles after, then raised -> no oe strobe before the rise; first strobe is sel0/addr0, the cycle after ready is sampled.
REQ-045 Core model returns rdata=addr^0xA5 and out_ready stalls 3 cycles per byte -> 32 bytes 0xA5..0xBA in addr order, out_data stable while stalled, one done pulse after byte 31, in_ready=1 next cycle.
